// File: rtl/e_md_scheduler.sv
// -----------------------------------------------------------------------------
// e_md_scheduler
//
// Multiply/divide scheduler for the E stage of the five-stage pipeline.
// Owns the architectural HI/LO registers. mult/multu/div/divu compute their
// full 64-bit result when they are accepted and park it in pend_hi/pend_lo.
// A busy countdown models the unit's fixed latency, and the parked result is
// committed to HI/LO on the edge where the countdown reaches zero. While the
// unit is starting or busy, any HI/LO instruction waiting in D is stalled.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (>= 1)
//   DIV_CYCLES   busy cycles for div/divu   (>= 1)
//
// Ports:
//   clk        in   system clock, all state updates on the rising edge
//   reset      in   synchronous, active-high
//   E_MDOp     in   E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                   5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9..15 none
//   E_ALUA     in   forwarded rs operand (multiplicand / dividend / mt value)
//   E_TrueRD2  in   forwarded rt operand (multiplier / divisor)
//   D_IsMD     in   D-stage instruction touches HI/LO
//   E_Start    out  a multiply/divide is accepted this cycle
//   E_Busy     out  countdown is nonzero (registered)
//   D_MDStall  out  hold the HI/LO instruction in D this cycle
//   E_MDRe     out  HI for mfhi, LO for mflo, else 0
//   HI, LO     out  architectural registers
// -----------------------------------------------------------------------------
module e_md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDOp,
    input  logic [31:0] E_ALUA,
    input  logic [31:0] E_TrueRD2,
    input  logic        D_IsMD,
    output logic        E_Start,
    output logic        E_Busy,
    output logic        D_MDStall,
    output logic [31:0] E_MDRe,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // State
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Decode
    logic busy;
    logic is_mul_op;
    logic is_div_op;
    logic start;

    assign busy      = (cnt_q != '0);
    assign is_mul_op = (E_MDOp == OP_MULT) || (E_MDOp == OP_MULTU);
    assign is_div_op = (E_MDOp == OP_DIV)  || (E_MDOp == OP_DIVU);
    assign start     = (is_mul_op || is_div_op) && !busy;

    // ------------------------------------------------------------------
    // Multiplier: the low 64 bits of the product of the operands extended
    // to 64 bits is the exact 64-bit product, signed or unsigned depending
    // on how the extension was done.
    // ------------------------------------------------------------------
    logic        mul_signed;
    logic [63:0] mul_a_ext;
    logic [63:0] mul_b_ext;
    logic [63:0] mul_prod;

    assign mul_signed = (E_MDOp == OP_MULT);
    assign mul_a_ext  = {{32{mul_signed & E_ALUA[31]}},    E_ALUA};
    assign mul_b_ext  = {{32{mul_signed & E_TrueRD2[31]}}, E_TrueRD2};
    assign mul_prod   = mul_a_ext * mul_b_ext;

    // ------------------------------------------------------------------
    // Divider: one unsigned divider serves both div and divu. For div the
    // operands are reduced to magnitudes and the signs re-applied after:
    // quotient negative when the operand signs differ, remainder takes the
    // dividend's sign. 0x80000000 has magnitude 0x80000000 as an unsigned
    // value, so 0x80000000 / -1 yields quotient 0x80000000, remainder 0.
    // ------------------------------------------------------------------
    logic        div_signed;
    logic        dvd_neg;
    logic        dvs_neg;
    logic        div_by_zero;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] dvs_safe;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign div_signed  = (E_MDOp == OP_DIV);
    assign dvd_neg     = div_signed & E_ALUA[31];
    assign dvs_neg     = div_signed & E_TrueRD2[31];
    assign div_by_zero = (E_TrueRD2 == 32'd0);
    assign dvd_mag     = dvd_neg ? (32'd0 - E_ALUA)    : E_ALUA;
    assign dvs_mag     = dvs_neg ? (32'd0 - E_TrueRD2) : E_TrueRD2;
    // The divide-by-zero result is discarded; substituting 1 keeps the
    // divider free of undefined behaviour.
    assign dvs_safe    = div_by_zero ? 32'd1 : dvs_mag;
    assign quo_mag     = dvd_mag / dvs_safe;
    assign rem_mag     = dvd_mag % dvs_safe;
    assign quo         = (dvd_neg ^ dvs_neg) ? (32'd0 - quo_mag) : quo_mag;
    assign rem         = dvd_neg ? (32'd0 - rem_mag) : rem_mag;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d gets a hold-value default first, so no path through
        // this block can leave a signal unassigned and infer a latch.
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        cnt_d     = cnt_q;

        if (start) begin
            if (is_mul_op) begin
                pend_hi_d = mul_prod[63:32];
                pend_lo_d = mul_prod[31:0];
                cnt_d     = CNT_W'(MULT_CYCLES);
            end else begin
                // A zero divisor parks the current HI/LO, so the eventual
                // commit leaves the architectural registers unchanged.
                pend_hi_d = div_by_zero ? hi_q : rem;
                pend_lo_d = div_by_zero ? lo_q : quo;
                cnt_d     = CNT_W'(DIV_CYCLES);
            end
        end else if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else begin
            // Idle: move-to ops write straight into HI/LO. Any op arriving
            // while busy is a protocol violation and is simply ignored.
            if (E_MDOp == OP_MTHI) begin
                hi_d = E_ALUA;
            end
            if (E_MDOp == OP_MTLO) begin
                lo_d = E_ALUA;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge value of every other flop, independent of statement order.
        if (reset) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            cnt_q     <= '0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            cnt_q     <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        E_MDRe = 32'd0;
        if (E_MDOp == OP_MFHI) begin
            E_MDRe = hi_q;
        end else if (E_MDOp == OP_MFLO) begin
            E_MDRe = lo_q;
        end
    end

    assign E_Start   = start;
    assign E_Busy    = busy;
    assign D_MDStall = D_IsMD & (start | busy);
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_e_md_scheduler.sv
// -----------------------------------------------------------------------------
// tb_e_md_scheduler
//
// Self-checking bench for e_md_scheduler. A cycle-indexed model records the
// cycle in which an operation started and its latency; busy, commit and
// stall behaviour are derived from that timestamp. A negedge process compares
// every DUT output against the model each cycle, and the directed sequence
// adds hand-computed literal checks on both DUT and model.
// -----------------------------------------------------------------------------
module tb_e_md_scheduler;

    localparam int MULT_L = 5;
    localparam int DIV_L  = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MDOp;
    logic [31:0] E_ALUA;
    logic [31:0] E_TrueRD2;
    logic        D_IsMD;
    logic        E_Start;
    logic        E_Busy;
    logic        D_MDStall;
    logic [31:0] E_MDRe;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;

    e_md_scheduler #(
        .MULT_CYCLES (MULT_L),
        .DIV_CYCLES  (DIV_L)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .E_MDOp    (E_MDOp),
        .E_ALUA    (E_ALUA),
        .E_TrueRD2 (E_TrueRD2),
        .D_IsMD    (D_IsMD),
        .E_Start   (E_Start),
        .E_Busy    (E_Busy),
        .D_MDStall (D_MDStall),
        .E_MDRe    (E_MDRe),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: cycle k runs from posedge k to posedge k+1. An accepted op in
    // cycle m_start keeps the unit busy in cycles m_start+1 .. m_start+m_len
    // and its result commits on the edge that ends the last busy cycle.
    // ------------------------------------------------------------------
    int          cyc         = 0;
    bit          model_valid = 1'b0;
    int          m_start     = -1000;
    int          m_len       = 0;
    logic [31:0] m_hi        = '0;
    logic [31:0] m_lo        = '0;
    logic [31:0] m_ph        = '0;
    logic [31:0] m_pl        = '0;

    function automatic bit m_busy_at(input int c);
        return (c > m_start) && (c <= m_start + m_len);
    endfunction

    function automatic bit is_start_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

    // Returns {hi, lo} the operation leaves in HI/LO.
    function automatic logic [63:0] md_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd1: begin
                p = 64'(sa * sb);
                return p;
            end
            4'd2: begin
                p = {32'd0, a} * {32'd0, b};
                return p;
            end
            4'd3: begin
                if (b == 32'd0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {hi, lo};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_hi        <= '0;
            m_lo        <= '0;
            m_start     <= -1000;
            m_len       <= 0;
            model_valid <= 1'b1;
        end else if (model_valid) begin
            if (m_busy_at(cyc) && (cyc == m_start + m_len)) begin
                m_hi <= m_ph;
                m_lo <= m_pl;
            end
            if (!m_busy_at(cyc)) begin
                if (is_start_op(E_MDOp)) begin
                    {m_ph, m_pl} <= md_result(E_MDOp, E_ALUA, E_TrueRD2, m_hi, m_lo);
                    m_start      <= cyc;
                    m_len        <= (E_MDOp <= 4'd2) ? MULT_L : DIV_L;
                end else if (E_MDOp == 4'd7) begin
                    m_hi <= E_ALUA;
                end else if (E_MDOp == 4'd8) begin
                    m_lo <= E_ALUA;
                end
            end
        end
        cyc <= cyc + 1;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            check("cmp_busy",  {31'd0, E_Busy},    {31'd0, m_busy_at(cyc)});
            check("cmp_start", {31'd0, E_Start},
                  {31'd0, is_start_op(E_MDOp) && !m_busy_at(cyc)});
            check("cmp_stall", {31'd0, D_MDStall},
                  {31'd0, D_IsMD && (is_start_op(E_MDOp) || m_busy_at(cyc))});
            check("cmp_mdre",  E_MDRe,
                  (E_MDOp == 4'd5) ? m_hi : ((E_MDOp == 4'd6) ? m_lo : 32'd0));
            check("cmp_hi", HI, m_hi);
            check("cmp_lo", LO, m_lo);
            if ((E_MDOp >= 4'd1) && (E_MDOp <= 4'd8)) begin
                check("no_md_while_busy", {31'd0, E_Busy}, 32'd0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        E_MDOp    = op;
        E_ALUA    = a;
        E_TrueRD2 = b;
        step();
        E_MDOp    = 4'd0;
        E_ALUA    = 32'd0;
        E_TrueRD2 = 32'd0;
    endtask

    // Counts busy cycles until idle, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (E_Busy && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int n;
        int n2;
        int stalls;
        int busycnt;

        reset     = 1'b1;
        E_MDOp    = 4'd0;
        E_ALUA    = 32'd0;
        E_TrueRD2 = 32'd0;
        D_IsMD    = 1'b0;
        step();
        step();
        check("reset_hi",   HI, 32'd0);
        check("reset_lo",   LO, 32'd0);
        check("reset_busy", {31'd0, E_Busy}, 32'd0);
        reset = 1'b0;
        step();

        // mult -3 * 5 with a mfhi waiting in D.
        E_MDOp    = 4'd1;
        E_ALUA    = 32'hFFFF_FFFD;
        E_TrueRD2 = 32'd5;
        D_IsMD    = 1'b1;
        stalls    = 0;
        busycnt   = 0;
        for (int i = 0; i < 40; i++) begin
            #3;
            if (E_Busy) busycnt++;
            if (!D_MDStall) break;
            stalls++;
            step();
            E_MDOp    = 4'd0;
            E_ALUA    = 32'd0;
            E_TrueRD2 = 32'd0;
        end
        check("mult_stall_cycles", stalls, 32'd6);
        check("mult_busy_cycles",  busycnt, 32'd5);
        E_MDOp = 4'd5;
        #1;
        check("mult_mfhi", E_MDRe, 32'hFFFF_FFFF);
        step();
        E_MDOp = 4'd0;
        D_IsMD = 1'b0;
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFF1);
        check("model_mult_lo", m_lo, 32'hFFFF_FFF1);

        // divu 100 / 7
        issue(4'd4, 32'd100, 32'd7);
        wait_idle(n);
        check("divu_busy", n, 32'd10);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);

        // div -7 / 2
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_neg_lo", LO, 32'hFFFF_FFFD);
        check("div_neg_hi", HI, 32'hFFFF_FFFF);
        check("model_div_neg_hi", m_hi, 32'hFFFF_FFFF);

        // div overflow case
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("div_ovf_lo", LO, 32'h8000_0000);
        check("div_ovf_hi", HI, 32'd0);
        check("model_div_ovf_lo", m_lo, 32'h8000_0000);

        // divide by zero leaves HI/LO unchanged
        issue(4'd7, 32'h11, 32'd0);
        issue(4'd8, 32'h22, 32'd0);
        check("mt_hi", HI, 32'h11);
        check("mt_lo", LO, 32'h22);
        issue(4'd3, 32'h1234, 32'd0);
        wait_idle(n);
        check("div0_busy", n, 32'd10);
        check("div0_hi", HI, 32'h11);
        check("div0_lo", LO, 32'h22);

        // mthi then reads; idle unit never stalls D
        issue(4'd7, 32'h1234_5678, 32'd0);
        D_IsMD = 1'b1;
        E_MDOp = 4'd6;
        #3;
        check("mflo_after_mthi", E_MDRe, 32'h22);
        check("idle_no_stall", {31'd0, D_MDStall}, 32'd0);
        E_MDOp = 4'd5;
        #1;
        check("mfhi_after_mthi", E_MDRe, 32'h1234_5678);
        E_MDOp = 4'd12;
        #1;
        check("nonmd_mdre", E_MDRe, 32'd0);
        step();
        E_MDOp = 4'd0;
        D_IsMD = 1'b0;
        step();

        // multu then reset two cycles later discards the result
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, E_Busy}, 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        for (int i = 0; i < 6; i++) step();
        check("rst_no_late_hi", HI, 32'd0);
        check("rst_no_late_lo", LO, 32'd0);

        // back-to-back mult then div
        issue(4'd1, 32'd7, 32'd9);
        wait_idle(n);
        E_MDOp    = 4'd3;
        E_ALUA    = 32'hFFFF_FF9C;
        E_TrueRD2 = 32'd7;
        #3;
        check("b2b_start_no_gap", {31'd0, E_Start}, 32'd1);
        step();
        E_MDOp    = 4'd0;
        E_ALUA    = 32'd0;
        E_TrueRD2 = 32'd0;
        check("b2b_mult_hold_lo", LO, 32'd63);
        wait_idle(n2);
        check("b2b_busy_total", n + n2, 32'd15);
        check("b2b_lo", LO, 32'hFFFF_FFF2);
        check("b2b_hi", HI, 32'hFFFF_FFFE);

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
